adder_pipe_buffer: RTL and testbench

//  Parametrised successor of the single-lane registered adder: LANES independent

---
 rtl/adder_pipe_buffer.sv | 150 +++++++++++++++
 tb/tb_adder_pipe_buffer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe_buffer.sv
// adder_pipe_buffer
//   LANES independent unsigned WIDTH-bit adders behind a valid/ready handshake.
//   Operands are registered (stage 1), summed and written into an OUT_DEPTH-entry
//   output FIFO (stage 2). Optional saturation clamps each lane to all-ones on
//   carry-out; the raw carry is reported per lane. Enable-gated synchronous flush.
//
// Ports
//   clk        rising-edge clock
//   rst_a_n    asynchronous reset, active low
//   enable     qualifies input acceptance and clr
//   clr        synchronous flush, effective only when enable=1
//   in_valid   producer has operands
//   in_ready   block accepts operands this cycle
//   input1     lane k operand A at [k*WIDTH +: WIDTH]
//   input2     lane k operand B, same packing
//   out_valid  FIFO head valid
//   out_ready  consumer takes head this cycle
//   data_out   FIFO head sums, same packing
//   out_ovf    FIFO head per-lane carry-out (raw, before clamp)
module adder_pipe_buffer #(
    parameter int unsigned WIDTH     = 5,
    parameter int unsigned LANES     = 1,
    parameter int unsigned SATURATE  = 0,
    parameter int unsigned OUT_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_a_n,
    input  logic                   enable,
    input  logic                   clr,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] input1,
    input  logic [LANES*WIDTH-1:0] input2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] data_out,
    output logic [LANES-1:0]       out_ovf
);

    localparam int unsigned DW = LANES * WIDTH;
    localparam int unsigned PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    localparam logic [CW:0]   DEPTH_C = (CW+1)'(OUT_DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    // Stage 1 registers
    logic          s1_v_q, s1_v_d;
    logic [DW-1:0] s1_a_q, s1_a_d;
    logic [DW-1:0] s1_b_q, s1_b_d;

    // Output FIFO
    logic [DW-1:0]    mem_data_q [OUT_DEPTH];
    logic [LANES-1:0] mem_ovf_q  [OUT_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic [CW:0]      credit_used;
    logic             flush;
    logic             accept;
    logic             push;
    logic             pop;

    logic [WIDTH:0]   lane_sum [LANES];
    logic [DW-1:0]    sum_res;
    logic [LANES-1:0] sum_ovf;

    // Credit check counts the stage-1 beat as already occupying a FIFO slot,
    // so an accepted beat always finds room and out_ready never reaches in_ready.
    assign credit_used = {1'b0, count_q} + {{CW{1'b0}}, s1_v_q};
    assign in_ready    = rst_a_n & enable & ~clr & (credit_used < DEPTH_C);

    assign flush  = enable & clr;
    assign accept = in_valid & in_ready;
    assign push   = s1_v_q;
    assign pop    = out_valid & out_ready;

    assign out_valid = (count_q != '0);
    assign data_out  = mem_data_q[rd_ptr_q];
    assign out_ovf   = mem_ovf_q[rd_ptr_q];

    // Stage 2 per-lane add with optional clamp
    always_comb begin
        lane_sum = '{default: '0};
        sum_res  = '0;
        sum_ovf  = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            lane_sum[k] = {1'b0, s1_a_q[k*WIDTH +: WIDTH]} + {1'b0, s1_b_q[k*WIDTH +: WIDTH]};
            sum_ovf[k]  = lane_sum[k][WIDTH];
            if ((SATURATE != 0) && lane_sum[k][WIDTH]) begin
                sum_res[k*WIDTH +: WIDTH] = '1;
            end else begin
                sum_res[k*WIDTH +: WIDTH] = lane_sum[k][WIDTH-1:0];
            end
        end
    end

    always_comb begin
        s1_v_d   = accept;
        s1_a_d   = accept ? input1 : s1_a_q;
        s1_b_d   = accept ? input2 : s1_b_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            s1_v_d   = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            s1_v_q   <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < OUT_DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_ovf_q[i]  <= '0;
            end
        end else begin
            s1_v_q   <= s1_v_d;
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            // Storage is left untouched by flush; only the pointers are reset.
            if (push && !flush) begin
                mem_data_q[wr_ptr_q] <= sum_res;
                mem_ovf_q[wr_ptr_q]  <= sum_ovf;
            end
        end
    end

endmodule

// File: tb/tb_adder_pipe_buffer.sv
// Bench for adder_pipe_buffer with WIDTH=5, LANES=2, OUT_DEPTH=2.
// A wrapping instance is checked against a scoreboard; a saturating instance
// shares the same stimulus and is checked in the saturation scenario.
module tb_adder_pipe_buffer;

    logic       clk;
    logic       rst_a_n;
    logic       enable;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] input1;
    logic [9:0] input2;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] data_out;
    logic [1:0] out_ovf;

    logic       s_in_ready;
    logic       s_out_valid;
    logic [9:0] s_data_out;
    logic [1:0] s_out_ovf;

    typedef struct packed {
        logic [1:0] o;
        logic [9:0] d;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   pops  = 0;

    adder_pipe_buffer #(.WIDTH(5), .LANES(2), .SATURATE(0), .OUT_DEPTH(2)) dut (
        .clk(clk), .rst_a_n(rst_a_n), .enable(enable), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .input1(input1), .input2(input2),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .out_ovf(out_ovf)
    );

    adder_pipe_buffer #(.WIDTH(5), .LANES(2), .SATURATE(1), .OUT_DEPTH(2)) dut_sat (
        .clk(clk), .rst_a_n(rst_a_n), .enable(enable), .clr(clr),
        .in_valid(in_valid), .in_ready(s_in_ready), .input1(input1), .input2(input2),
        .out_valid(s_out_valid), .out_ready(out_ready), .data_out(s_data_out), .out_ovf(s_out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [9:0] a, input logic [9:0] b, input bit sat);
        exp_t       r;
        logic [5:0] s;
        r = '0;
        for (int k = 0; k < 2; k++) begin
            s = 6'(a[k*5 +: 5]) + 6'(b[k*5 +: 5]);
            r.o[k] = s[5];
            r.d[k*5 +: 5] = (sat && s[5]) ? 5'h1f : s[4:0];
        end
        return r;
    endfunction

    // Scoreboard: evaluated mid-cycle for what the next rising edge will do.
    always @(negedge clk) begin
        exp_t e;
        if (rst_a_n) begin
            if (enable && clr) begin
                sb_q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    total++;
                    pops++;
                    if (sb_q.size() == 0) begin
                        bad++;
                        $display("FAIL sb_unexpected_pop: got d=%h o=%b want no output", data_out, out_ovf);
                    end else begin
                        e = sb_q.pop_front();
                        if (data_out !== e.d || out_ovf !== e.o) begin
                            bad++;
                            $display("FAIL sb_data: got d=%h o=%b want d=%h o=%b", data_out, out_ovf, e.d, e.o);
                        end
                    end
                end
                if (in_valid && in_ready) sb_q.push_back(model(input1, input2, 1'b0));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a_n = 1'b0; enable = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        input1 = '0; input2 = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        total++; if (data_out !== 10'h0) begin bad++; $display("FAIL rst_data_out: got %h want 000", data_out); end
        total++; if (out_ovf !== 2'b00) begin bad++; $display("FAIL rst_out_ovf: got %b want 00", out_ovf); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        rst_a_n = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0 || data_out !== 10'h0) begin bad++; $display("FAIL rel_out: got v=%b d=%h want v=0 d=000", out_valid, data_out); end
        enable = 1'b0;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rel_in_ready_dis: got %b want 0", in_ready); end
        enable = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        input1 = {5'd10, 5'd3};
        input2 = {5'd5, 5'd4};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_lat1: got %b want 0", out_valid); end
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", out_valid); end
        total++; if (data_out !== {5'd15, 5'd7} || out_ovf !== 2'b00) begin
            bad++; $display("FAIL basic_data: got d=%h o=%b want d=%h o=00", data_out, out_ovf, {5'd15, 5'd7});
        end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_pulse: got %b want 0", out_valid); end
        tick();
    endtask

    task automatic test_saturate();
        logic [9:0] va [3];
        logic [9:0] vb [3];
        exp_t       ew, es;
        va[0] = {5'd1, 5'd20};  vb[0] = {5'd2, 5'd20};
        va[1] = {5'd16, 5'd31}; vb[1] = {5'd16, 5'd0};
        va[2] = {5'd0, 5'd31};  vb[2] = {5'd0, 5'd31};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            input1 = va[i]; input2 = vb[i]; in_valid = 1'b1;
            ew = model(va[i], vb[i], 1'b0);
            es = model(va[i], vb[i], 1'b1);
            tick();
            in_valid = 1'b0;
            @(negedge clk);
            @(negedge clk);
            total++; if (out_valid !== 1'b1 || data_out !== ew.d || out_ovf !== ew.o) begin
                bad++; $display("FAIL wrap_%0d: got v=%b d=%h o=%b want v=1 d=%h o=%b", i, out_valid, data_out, out_ovf, ew.d, ew.o);
            end
            total++; if (s_out_valid !== 1'b1 || s_data_out !== es.d || s_out_ovf !== es.o) begin
                bad++; $display("FAIL sat_%0d: got v=%b d=%h o=%b want v=1 d=%h o=%b", i, s_out_valid, s_data_out, s_out_ovf, es.d, es.o);
            end
            tick();
        end
        tick();
    endtask

    task automatic test_backpressure();
        int i;
        int p0;
        i = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            input1 = 10'($urandom); input2 = 10'($urandom);
            @(negedge clk);
            if (c == 2) begin
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready3: got %b want 0", in_ready); end
            end
            if (in_valid && in_ready) i++;
            tick();
        end
        total++; if (i != 2) begin bad++; $display("FAIL bp_accepted: got %0d want 2", i); end
        p0 = pops;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && (i < 4 || out_valid); c++) begin
            in_valid = (i < 4);
            @(negedge clk);
            if (in_valid && in_ready) begin
                i++;
                input1 = 10'($urandom); input2 = 10'($urandom);
            end
            tick();
        end
        in_valid = 1'b0;
        total++; if (i != 4 || pops - p0 != 4) begin bad++; $display("FAIL bp_drain: got acc=%0d pops=%0d want acc=4 pops=4", i, pops - p0); end
        total++; if (sb_q.size() != 0) begin bad++; $display("FAIL bp_sb_left: got %0d want 0", sb_q.size()); end
    endtask

    task automatic test_clr();
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (c < 2);
            input1 = 10'($urandom); input2 = 10'($urandom);
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL clr_full: got v=%b r=%b want v=1 r=0", out_valid, in_ready); end
        tick();
        clr = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL clr_in_ready: got %b want 0", in_ready); end
        tick();
        clr = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL clr_flushed: got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
        tick();
        // clr without enable is ignored
        out_ready = 1'b0;
        input1 = 10'($urandom); input2 = 10'($urandom); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        enable = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL clr_noen: got %b want 1", out_valid); end
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || sb_q.size() != 0) begin bad++; $display("FAIL dis_pop: got v=%b sb=%0d want v=0 sb=0", out_valid, sb_q.size()); end
        // in-flight beat drains after enable drops
        enable = 1'b1;
        input1 = 10'($urandom); input2 = 10'($urandom); in_valid = 1'b1;
        tick();
        enable = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL dis_stage1: got r=%b v=%b want r=0 v=0", in_ready, out_valid); end
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL dis_drain: got %b want 1", out_valid); end
        tick();
        in_valid = 1'b0; enable = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || sb_q.size() != 0) begin bad++; $display("FAIL dis_done: got v=%b sb=%0d want v=0 sb=0", out_valid, sb_q.size()); end
        tick();
    endtask

    task automatic test_random();
        int p0;
        p0 = pops;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            enable    = ($urandom_range(0, 7) != 0);
            clr       = ($urandom_range(0, 39) == 0);
            input1 = 10'($urandom); input2 = 10'($urandom);
            tick();
        end
        in_valid = 1'b0; clr = 1'b0; enable = 1'b1; out_ready = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || sb_q.size() != 0) begin bad++; $display("FAIL rnd_drain: got v=%b sb=%0d want v=0 sb=0", out_valid, sb_q.size()); end
        total++; if (pops - p0 < 50) begin bad++; $display("FAIL rnd_pops: got %0d want >=50", pops - p0); end
        tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; enable = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            input1 = 10'($urandom); input2 = 10'($urandom);
            tick();
        end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ar_pre: got %b want 1", out_valid); end
        #2;
        rst_a_n = 1'b0;
        sb_q.delete();
        #1;
        total++; if (out_valid !== 1'b0 || data_out !== 10'h0 || out_ovf !== 2'b00 || in_ready !== 1'b0) begin
            bad++; $display("FAIL ar_clear: got v=%b d=%h o=%b r=%b want v=0 d=000 o=00 r=0", out_valid, data_out, out_ovf, in_ready);
        end
        tick();
        rst_a_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL ar_after: got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
        tick();
        input1 = {5'd31, 5'd9}; input2 = {5'd1, 5'd9}; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        total++; if (sb_q.size() != 0) begin bad++; $display("FAIL ar_final_sb: got %0d want 0", sb_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_backpressure();
        test_clr();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
